// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared encodings, seeds and pattern step function for led_seq_ctrl
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_UP     = 2'd0,
    MODE_DOWN   = 2'd1,
    MODE_ROT    = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  localparam logic [7:0] SEED_UP     = 8'h00;
  localparam logic [7:0] SEED_DOWN   = 8'hFF;
  localparam logic [7:0] SEED_ROT    = 8'h01;
  localparam logic [7:0] SEED_BOUNCE = 8'h01;

  typedef struct packed {
    logic [7:0] ld;
    dir_e       dir;
  } pat_t;

  function automatic logic [7:0] seed_of(input mode_e m);
    case (m)
      MODE_UP:   return SEED_UP;
      MODE_DOWN: return SEED_DOWN;
      MODE_ROT:  return SEED_ROT;
      default:   return SEED_BOUNCE;
    endcase
  endfunction

  // Bounce turns on the step leaving an end, so each end is shown exactly once.
  function automatic pat_t next_pat(input mode_e m, input logic [7:0] ld, input dir_e dir);
    pat_t r;
    r.ld  = ld;
    r.dir = dir;
    case (m)
      MODE_UP:   r.ld = ld + 8'd1;
      MODE_DOWN: r.ld = ld - 8'd1;
      MODE_ROT:  r.ld = {ld[6:0], ld[7]};
      default: begin
        if (dir == DIR_LEFT) begin
          if (ld == 8'h80) begin
            r.ld  = 8'h40;
            r.dir = DIR_RIGHT;
          end else begin
            r.ld = {ld[6:0], 1'b0};
          end
        end else begin
          if (ld == 8'h01) begin
            r.ld  = 8'h02;
            r.dir = DIR_LEFT;
          end else begin
            r.ld = {1'b0, ld[7:1]};
          end
        end
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/led_seq_ctrl_tick_gen.sv
// rtl/led_seq_ctrl_tick_gen.sv - TICK_DIV prescaler producing a one-cycle tick strobe
module tick_gen #(
  parameter int TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic res,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// rtl/led_seq_ctrl.sv - LED pattern sequencer with idle/run/pause control and prescaled stepping
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV = 100000000,
  parameter int LD_W     = 8
) (
  input  logic            clk,
  input  logic            res,
  input  logic            start,
  input  logic            stop,
  input  logic            step,
  input  logic            clear,
  input  logic [1:0]      mode,
  output logic [LD_W-1:0] LD,
  output logic            busy,
  output logic            paused,
  output logic            tick
);

  state_e          state_q, state_d;
  mode_e           mode_q, mode_d;
  dir_e            dir_q, dir_d;
  logic [LD_W-1:0] ld_d;
  logic            run_hold;
  pat_t            nxt;

  // Prescaler only counts while RUN is held; leaving RUN (stop/clear) zeroes it.
  assign run_hold = (state_q == RUN) && !clear && !stop;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .res  (res),
    .en   (run_hold),
    .clr  (!run_hold),
    .tick (tick)
  );

  assign nxt    = next_pat(mode_q, LD, dir_q);
  assign busy   = (state_q != IDLE);
  assign paused = (state_q == PAUSE);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    ld_d    = LD;
    if (clear) begin
      state_d = IDLE;
      ld_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = RUN;
            mode_d  = mode_e'(mode);
            ld_d    = seed_of(mode_e'(mode));
            dir_d   = DIR_LEFT;
          end
        end
        RUN: begin
          if (stop) begin
            state_d = PAUSE;
          end else if (tick) begin
            ld_d  = nxt.ld;
            dir_d = nxt.dir;
          end
        end
        PAUSE: begin
          if (start) begin
            state_d = RUN;
          end else if (step) begin
            ld_d  = nxt.ld;
            dir_d = nxt.dir;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= IDLE;
      mode_q  <= MODE_UP;
      dir_q   <= DIR_LEFT;
      LD      <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      LD      <= ld_d;
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb/tb_led_seq_ctrl.sv - scoreboard bench for led_seq_ctrl with TICK_DIV=4
module tb_led_seq_ctrl;

  logic       clk;
  logic       res;
  logic       start, stop, step, clear;
  logic [1:0] mode;
  logic [7:0] LD;
  logic       busy, paused, tick;

  typedef struct {
    logic [7:0] ld;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  led_seq_ctrl #(.TICK_DIV(4), .LD_W(8)) dut (
    .clk    (clk),
    .res    (res),
    .start  (start),
    .stop   (stop),
    .step   (step),
    .clear  (clear),
    .mode   (mode),
    .LD     (LD),
    .busy   (busy),
    .paused (paused),
    .tick   (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // s = {clear, stop, start, step}; returns 1 time unit after the acting edge
  task automatic strobe(input logic [3:0] s);
    @(negedge clk);
    {clear, stop, start, step} = s;
    @(posedge clk);
    #1;
    {clear, stop, start, step} = 4'b0000;
  endtask

  task automatic push_run(input logic [7:0] first_ld, input int n, input int c0, input int m);
    logic [7:0] v;
    v = first_ld;
    for (int k = 1; k <= n; k++) begin
      q.push_back('{ld: v, cyc: c0 + 4 * k - 1});
      if (m == 0) v = v + 8'd1;
      else if (m == 1) v = v - 8'd1;
      else v = {v[6:0], v[7]};
    end
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (q.size() != 0 && n < bound) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  // Monitor: every tick must match the next scoreboard entry in cycle and resulting LD.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (tick === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_tick", tick, 0);
        end else begin
          e = q.pop_front();
          chk("tick_cycle", cyc, e.cyc);
          @(posedge clk);
          #1;
          chk("ld_after_tick", LD, e.ld);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0;
    logic [7:0] bounce_seq [16];
    bounce_seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                   8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
    res = 1'b0;
    {clear, stop, start, step} = 4'b0000;
    mode = 2'd0;
    #12;
    chk("rst_ld", LD, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_paused", paused, 0);
    chk("rst_tick", tick, 0);
    @(negedge clk);
    res = 1'b1;

    // count up, full wrap through 256 ticks
    mode = 2'd0;
    strobe(4'b0010);
    c0 = cyc;
    chk("up_seed", LD, 8'h00);
    chk("up_busy", busy, 1);
    push_run(8'h01, 256, c0, 0);
    drain(1100);
    chk("up_wrap", LD, 8'h00);
    strobe(4'b1000);
    chk("clr_busy", busy, 0);

    // bounce
    mode = 2'd3;
    strobe(4'b0010);
    c0 = cyc;
    chk("bnc_seed", LD, 8'h01);
    for (int k = 0; k < 16; k++) q.push_back('{ld: bounce_seq[k], cyc: c0 + 4 * k + 3});
    drain(100);
    strobe(4'b1000);

    // count down, pause and single-step
    mode = 2'd1;
    strobe(4'b0010);
    c0 = cyc;
    chk("dn_seed", LD, 8'hFF);
    push_run(8'hFE, 2, c0, 1);
    drain(20);
    strobe(4'b0100);
    chk("pause_flag", paused, 1);
    chk("pause_ld", LD, 8'hFD);
    repeat (10) @(posedge clk);
    strobe(4'b0001);
    chk("step1_ld", LD, 8'hFC);
    chk("step1_paused", paused, 1);
    strobe(4'b0001);
    chk("step2_ld", LD, 8'hFB);
    strobe(4'b0010);
    c0 = cyc;
    chk("resume_paused", paused, 0);
    q.push_back('{ld: 8'hFA, cyc: c0 + 3});
    drain(20);

    // clear wins over start and stop; stop/step ignored in IDLE
    strobe(4'b1110);
    chk("prio_ld", LD, 8'h00);
    chk("prio_busy", busy, 0);
    strobe(4'b0100);
    chk("idle_stop_busy", busy, 0);
    strobe(4'b0001);
    chk("idle_step_ld", LD, 8'h00);
    chk("idle_step_busy", busy, 0);

    // rotate; mode change mid-run must not take effect
    mode = 2'd2;
    strobe(4'b0010);
    c0 = cyc;
    chk("rot_seed", LD, 8'h01);
    mode = 2'd0;
    push_run(8'h02, 3, c0, 2);
    drain(30);
    strobe(4'b1000);
    strobe(4'b0010);
    c0 = cyc;
    chk("up2_seed", LD, 8'h00);
    q.push_back('{ld: 8'h01, cyc: c0 + 3});
    drain(20);

    // asynchronous reset mid-cycle during RUN
    #1;
    res = 1'b0;
    #1;
    chk("async_ld", LD, 8'h00);
    chk("async_busy", busy, 0);
    chk("async_tick", tick, 0);
    @(negedge clk);
    res = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ld", LD, 8'h00);
    chk("queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
Controller that sequences the 8-bit LED output register on the board. It owns a programmable tick prescaler, a run/pause/idle state machine and four pattern modes (count up, count down, rotate, bounce). Front-panel logic drives it through start/stop/step/clear strobes, and LD drives the LED pins directly.

Parameters:
TICK_DIV, 100000000, clock cycles per pattern step (1 s at 100 MHz); legal range 2 to 2**28-1
LD_W, 8, LED register width; fixed at 8 for this revision

Ports:
clk  in  1  system clock
res  in  1  reset; one clock; reset is asynchronous and active-low
start  in  1  single-cycle strobe: begin from IDLE, resume from PAUSE
stop  in  1  single-cycle strobe: RUN -> PAUSE
step  in  1  single-cycle strobe: in PAUSE, advance pattern once
clear  in  1  single-cycle strobe: any state -> IDLE, LD cleared
mode  in  2  pattern select; sampled only on IDLE->RUN
LD  out  8  LED pattern, registered
busy  out  1  high when state != IDLE
paused  out  1  high when state == PAUSE
tick  out  1  one-cycle strobe on each prescaler-driven update

Behaviour:
- Reset (res=0, async): LD=0x00, state=IDLE, mode_q=0, dir_q=left, prescaler count=0, tick=0. busy and paused are decoded from the state register, so both are 0.
- Strobe priority when several are asserted in the same cycle: clear > stop > start > step. Only the highest-priority strobe that is legal in the current state acts. All others are ignored.
- States:
  - IDLE: start -> RUN. On that edge, mode_q<=mode, LD<=seed(mode), dir_q<=left, prescaler<=0. Strobes stop and step are ignored.
  - RUN: the prescaler increments every cycle. When count==TICK_DIV-1: tick=1, count<=0, LD<=next(LD). stop -> PAUSE with prescaler cleared and LD held. start and step are ignored.
  - PAUSE: start -> RUN with no reseed and prescaler=0. step -> LD<=next(LD) on the next edge with tick staying 0, and the state remains PAUSE.
  - Any state: clear -> IDLE, LD<=0x00, prescaler<=0.
- Timing: tick is combinational from the count compare and is gated by RUN. The first update lands exactly TICK_DIV cycles after the start edge, and updates then repeat every TICK_DIV cycles.
- Modes, as mode_q -> seed / next(LD):
  - 0 UP: seed 0x00; LD+1 mod 256 (0xFF -> 0x00).
  - 1 DOWN: seed 0xFF; LD-1 mod 256 (0x00 -> 0xFF).
  - 2 ROTATE: seed 0x01; rotate left 1 (0x80 -> 0x01).
  - 3 BOUNCE: seed 0x01, dir=left; shift in dir. At 0x80 the next step is 0x40 and dir becomes right. At 0x01 the next step is 0x02 and dir becomes left. The turn happens on the step leaving an end, so each end is shown for exactly one step.
- A mode change during RUN or PAUSE has no effect until the next IDLE->RUN transition.
- Reset asserted mid-run returns all state to reset values immediately, with no glitch-protection requirement on LD.
- All arithmetic is 8-bit with wrap-around. The prescaler width is clog2(TICK_DIV).

Decomposition:
- Package led_seq_pkg contains:
  - mode encodings MODE_UP=0, MODE_DOWN=1, MODE_ROT=2, MODE_BOUNCE=3
  - state encodings IDLE, RUN, PAUSE
  - seed constants per mode
  - direction encoding
- Sub-module tick_gen (ports clk, res, en, clr, tick): holds the TICK_DIV prescaler so the prescaler can be reused and unit-tested alone.
- Pattern next-state logic is a function in the package. The controller FSM stays in led_seq_ctrl.

Test Plan (all scenarios use TICK_DIV=4):
- Reset, then start with mode=0 -> LD=0x00 after the start edge; tick at cycles 4, 8, 12; LD=0x01, 0x02, 0x03. Apply 256 ticks -> LD wraps 0xFF -> 0x00.
- Start with mode=3, run 16 ticks -> LD sequence 02,04,08,10,20,40,80,40,20,10,08,04,02,01,02,04.
- Run mode=1 to LD=0xFD, stop, step twice, start -> paused=1 while stopped; LD=0xFC then 0xFB; tick stays 0 while paused; next tick comes 4 cycles after start and gives LD=0xFA.
- Assert start, stop and clear together in RUN -> state IDLE, LD=0x00, busy=0. Then stop and step alone in IDLE -> no change.
- Start with mode=2, change mode to 0 mid-run -> rotate continues 0x01, 0x02, 0x04. Clear, then start -> count-up from 0x00.
- Assert res=0 asynchronously between clock edges during RUN -> LD=0x00, busy=0 and tick=0 before the next edge. Release reset -> remains IDLE.
